// File: rtl/dp_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, ALU function
// codes, controller states and the decoded control vector.
package dp_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_WND   = 4'b0011;
    localparam logic [3:0] OP_BRZ   = 4'b0100;
    localparam logic [3:0] OP_HLT   = 4'b0111;
    localparam logic [3:0] OP_CTYPE = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1100;
    localparam logic [3:0] OP_SUBI  = 4'b1101;
    localparam logic [3:0] OP_ANDI  = 4'b1110;
    localparam logic [3:0] OP_ORI   = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOT   = 3'b100;
    localparam logic [2:0] ALU_PASS1 = 3'b101;
    localparam logic [2:0] ALU_PASS2 = 3'b110;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Control vector for one cycle of single-cycle execution
    typedef struct packed {
        logic       ld_pc;
        logic       pc_sel;
        logic       branch_sel;
        logic       jump_sel;
        logic       reg_sel;
        logic       in_sel;
        logic       sel_dm;
        logic       sel_alu;
        logic       reg_write;
        logic       nop;
        logic       ld_wnd;
        logic       mem_write;
        logic       mem_read;
        logic [2:0] func_ctrl;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Idle vector: no strobes, PC holds, nop=1 means "not a NOP"
    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c     = '0;
        c.nop = 1'b1;
        return c;
    endfunction

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/dp_sequencer_decode.sv
// Combinational opcode/function decoder producing the single-cycle control
// vector plus classification flags used by the sequencer.
module dp_decode
    import dp_pkg::*;
(
    input  logic [3:0]        inst_op,
    input  logic [7:0]        func,
    output logic [CTRL_W-1:0] ctrl_vec,
    output logic              is_load,
    output logic              is_store,
    output logic              is_hlt,
    output logic              is_illegal
);

    ctrl_t c;

    // Decode opcode and C-type function field into the control vector
    always_comb begin
        c          = idle_ctrl();
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_hlt     = 1'b0;
        is_illegal = 1'b0;
        case (inst_op)
            OP_LOAD: begin
                is_load     = 1'b1;
                c.ld_pc     = 1'b1;
                c.pc_sel    = 1'b1;
                c.mem_read  = 1'b1;
                c.sel_dm    = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_STORE: begin
                is_store    = 1'b1;
                c.ld_pc     = 1'b1;
                c.pc_sel    = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_JUMP: begin
                c.ld_pc    = 1'b1;
                c.jump_sel = 1'b1;
            end
            OP_WND: begin
                c.ld_pc  = 1'b1;
                c.pc_sel = 1'b1;
                c.ld_wnd = 1'b1;
            end
            OP_BRZ: begin
                c.ld_pc      = 1'b1;
                c.pc_sel     = 1'b1;
                c.branch_sel = 1'b1;
            end
            OP_HLT: begin
                is_hlt   = 1'b1;
                c.ld_pc  = 1'b1;
                c.pc_sel = 1'b1;
            end
            OP_CTYPE: begin
                c.ld_pc  = 1'b1;
                c.pc_sel = 1'b1;
                if (is_onehot8(func)) begin
                    c.reg_sel   = 1'b1;
                    c.sel_alu   = 1'b1;
                    c.reg_write = 1'b1;
                    case (func)
                        8'h01:   c.func_ctrl = ALU_PASS2;
                        8'h02:   c.func_ctrl = ALU_PASS1;
                        8'h04:   c.func_ctrl = ALU_ADD;
                        8'h08:   c.func_ctrl = ALU_SUB;
                        8'h10:   c.func_ctrl = ALU_AND;
                        8'h20:   c.func_ctrl = ALU_OR;
                        8'h40:   c.func_ctrl = ALU_NOT;
                        8'h80: begin
                            c.nop       = 1'b0;
                            c.reg_write = 1'b0;
                        end
                        default: c.func_ctrl = ALU_ADD;
                    endcase
                end else begin
                    c.nop      = 1'b0;
                    is_illegal = 1'b1;
                end
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                c.ld_pc     = 1'b1;
                c.pc_sel    = 1'b1;
                c.in_sel    = 1'b1;
                c.sel_alu   = 1'b1;
                c.reg_write = 1'b1;
                case (inst_op)
                    OP_SUBI: c.func_ctrl = ALU_SUB;
                    OP_ANDI: c.func_ctrl = ALU_AND;
                    OP_ORI:  c.func_ctrl = ALU_OR;
                    default: c.func_ctrl = ALU_ADD;
                endcase
            end
            default: begin
                c.ld_pc    = 1'b1;
                c.pc_sel   = 1'b1;
                c.nop      = 1'b0;
                is_illegal = 1'b1;
            end
        endcase
    end

    assign ctrl_vec = c;

endmodule

// File: rtl/dp_sequencer.sv
// Datapath controller: decodes the current instruction and sequences
// post-reset PC hold, data-memory wait states, HLT and run/step debug.
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int RST_CYC = 2,
    parameter int DM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] instOut,
    input  logic [7:0] funcOut,
    input  logic       run,
    input  logic       step,
    output logic       rstPC,
    output logic       ldPC,
    output logic       pcSel,
    output logic       branchSel,
    output logic       jumpSel,
    output logic       regSel,
    output logic       inSel,
    output logic       selDm,
    output logic       selALU,
    output logic       regWrite,
    output logic       nop,
    output logic       ldWnd,
    output logic [1:0] wndCtrl,
    output logic       memWrite,
    output logic       memRead,
    output logic [2:0] funcCtrl,
    output logic       halted,
    output logic       illegal
);

    // Reset hold counter is 8 bits wide, so RST_CYC may range 1..256
    localparam logic [7:0] RST_LAST = 8'(RST_CYC - 1);
    localparam logic [3:0] WAIT_CYC = 4'(DM_WAIT);

    logic [CTRL_W-1:0] dec_vec;
    ctrl_t             dec_ctrl;
    logic              dec_load;
    logic              dec_store;
    logic              dec_hlt;
    logic              dec_illegal;

    state_e     state_q, state_d;
    logic [7:0] rst_cnt_q, rst_cnt_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       illegal_q, illegal_d;
    logic       step_pend_q, step_pend_d;
    logic       mem_load_q, mem_load_d;
    logic       run_prev_q;
    logic       step_prev_q;

    ctrl_t out_c;
    logic  rst_pc_c;
    logic  run_rise;
    logic  step_rise;

    dp_decode u_decode (
        .inst_op    (instOut),
        .func       (funcOut),
        .ctrl_vec   (dec_vec),
        .is_load    (dec_load),
        .is_store   (dec_store),
        .is_hlt     (dec_hlt),
        .is_illegal (dec_illegal)
    );

    assign dec_ctrl  = ctrl_t'(dec_vec);
    assign run_rise  = run & ~run_prev_q;
    assign step_rise = step & ~step_prev_q;

    // Next-state, counters and gated control outputs
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        wcnt_d      = wcnt_q;
        illegal_d   = illegal_q;
        step_pend_d = step_pend_q;
        mem_load_d  = mem_load_q;
        out_c       = idle_ctrl();
        rst_pc_c    = 1'b0;
        case (state_q)
            ST_RST: begin
                rst_pc_c = 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = run ? ST_EXEC : ST_HALT;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            ST_EXEC: begin
                if (!run && !step_pend_q) begin
                    state_d = ST_HALT;
                end else begin
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end
                    if ((dec_load || dec_store) && (WAIT_CYC != 4'd0)) begin
                        out_c.mem_read = dec_load;
                        wcnt_d         = WAIT_CYC;
                        mem_load_d     = dec_load;
                        state_d        = ST_MEM;
                    end else begin
                        out_c       = dec_ctrl;
                        step_pend_d = 1'b0;
                        if (dec_hlt) begin
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_MEM: begin
                out_c.mem_read = mem_load_q;
                wcnt_d         = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    out_c.ld_pc  = 1'b1;
                    out_c.pc_sel = 1'b1;
                    if (mem_load_q) begin
                        out_c.sel_dm    = 1'b1;
                        out_c.reg_write = 1'b1;
                    end else begin
                        out_c.mem_write = 1'b1;
                    end
                    step_pend_d = 1'b0;
                    state_d     = (run || step_pend_q) ? ST_EXEC : ST_HALT;
                end
            end
            ST_HALT: begin
                if (run_rise) begin
                    state_d = ST_EXEC;
                end else if (step_rise) begin
                    step_pend_d = 1'b1;
                    state_d     = ST_EXEC;
                end
            end
            default: state_d = ST_RST;
        endcase
    end

    // State, counters, sticky flag and edge-detect registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RST;
            rst_cnt_q   <= 8'd0;
            wcnt_q      <= 4'd0;
            illegal_q   <= 1'b0;
            step_pend_q <= 1'b0;
            mem_load_q  <= 1'b0;
            run_prev_q  <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            wcnt_q      <= wcnt_d;
            illegal_q   <= illegal_d;
            step_pend_q <= step_pend_d;
            mem_load_q  <= mem_load_d;
            run_prev_q  <= run;
            step_prev_q <= step;
        end
    end

    assign rstPC     = rst_pc_c;
    assign ldPC      = out_c.ld_pc;
    assign pcSel     = out_c.pc_sel;
    assign branchSel = out_c.branch_sel;
    assign jumpSel   = out_c.jump_sel;
    assign regSel    = out_c.reg_sel;
    assign inSel     = out_c.in_sel;
    assign selDm     = out_c.sel_dm;
    assign selALU    = out_c.sel_alu;
    assign regWrite  = out_c.reg_write;
    assign nop       = out_c.nop;
    assign ldWnd     = out_c.ld_wnd;
    assign memWrite  = out_c.mem_write;
    assign memRead   = out_c.mem_read;
    assign funcCtrl  = out_c.func_ctrl;
    assign wndCtrl   = (state_q == ST_RST) ? 2'b00 : funcOut[1:0];
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
Multi-state controller that decodes `instOut`/`funcOut` from the single-cycle datapath and drives every datapath control input. It adds the following sequencing on top of plain decode:
- post-reset PC-clear hold
- configurable data-memory wait states
- HLT instruction
- run/halt/single-step debug control
- illegal-opcode flagging

It sits beside the datapath in the processor top level and replaces a purely combinational decoder.

Parameters:
- `RST_CYC`, default 2: cycles `rstPC` is held after reset release (≥1).
- `DM_WAIT`, default 0: extra cycles per LOAD/STORE (0–15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instOut`  in  4  opcode (ins[15:12]).
- `funcOut`  in  8  C-type function field (ins[7:0]), one-hot.
- `run`  in  1  level; 1 = free-run, 0 = halt at the next instruction boundary.
- `step`  in  1  rising edge while halted executes exactly one instruction.
- `rstPC`, `ldPC`, `pcSel`, `branchSel`, `jumpSel`  out  1 each  PC control.
- `regSel`, `inSel`  out  1 each  ALU operand-1 select (one-hot).
- `selDm`, `selALU`  out  1 each  write-back select (one-hot).
- `regWrite`, `nop`  out  1 each  register write; `nop`=1 means "not a NOP" (write enabled).
- `ldWnd`  out  1  load window register.
- `wndCtrl`  out  2  window value (= funcOut[1:0]).
- `memWrite`, `memRead`  out  1 each  data-memory strobes.
- `funcCtrl`  out  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 PASS1, 110 PASS2.
- `halted`  out  1  state is HALT.
- `illegal`  out  1  sticky; set on an undefined opcode or a non-one-hot C-type function.

Behaviour:
- States: RST, EXEC, MEM, HALT. Encoding is 2-bit: RST=0, EXEC=1, MEM=2, HALT=3.
- Reset:
  - `rst`=0 asynchronously forces state RST, counters 0, `illegal`=0, and the run/step edge registers to 0.
  - In RST: `rstPC`=1; every other output is 0, except `nop`=1 and `halted`=0.
- RST exit: after `RST_CYC` cycles with `rst`=1, go to EXEC if `run`=1, else HALT.
- Default (idle) outputs, used in RST/HALT/MEM and for suppressed cycles:
  - all strobes 0, `ldPC`=0 (PC holds), `funcCtrl`=000, `nop`=1.
- EXEC boundary check: if `run`=0 and no step is pending, emit defaults and go to HALT with no instruction issued.
- EXEC decode; every issued instruction asserts `ldPC`=1 unless stated otherwise.
  - 0000 LOAD:
    - `memRead`=1.
    - `DM_WAIT`=0: `selDm`=1, `regWrite`=1, `pcSel`=1 this cycle.
    - `DM_WAIT`>0: `ldPC`=0, go to MEM.
  - 0001 STORE:
    - `DM_WAIT`=0: `memWrite`=1, `pcSel`=1.
    - `DM_WAIT`>0: `memRead`=0, `memWrite`=0, `ldPC`=0, go to MEM.
  - 0010 JUMP: `jumpSel`=1.
  - 0011 WND: `ldWnd`=1, `pcSel`=1.
  - 0100 BRZ: `branchSel`=1, `pcSel`=1. The datapath gates the branch with zero; the branch target has priority inside the PC mux.
  - 0111 HLT: `pcSel`=1 (PC advances), then go to HALT.
  - 1000 C-type: `regSel`=1, `selALU`=1, `regWrite`=1, `pcSel`=1. `funcCtrl` by `funcOut`:
    - bit0 → 110, bit1 → 101, bit2 → 000, bit3 → 001, bit4 → 010, bit5 → 011, bit6 → 100.
    - bit7 (NOP) → `nop`=0, `regWrite`=0.
  - 1100/1101/1110/1111 ADDI/SUBI/ANDI/ORI: `inSel`=1, `selALU`=1, `regWrite`=1, `pcSel`=1, `funcCtrl`=000/001/010/011.
  - Any other opcode, or `funcOut` not one-hot for C-type: treat as NOP (`nop`=0, `pcSel`=1) and set `illegal`.
- MEM, counter `wcnt` loaded with `DM_WAIT` on entry:
  - `memRead`=1 (LOAD) every MEM cycle; decrement each cycle.
  - Final cycle (`wcnt`=1):
    - LOAD: `selDm`=1, `regWrite`=1, `ldPC`=1, `pcSel`=1.
    - STORE: `memWrite`=1 for exactly this one cycle, `ldPC`=1, `pcSel`=1.
  - MEM completion then goes to EXEC if `run`=1 or a step is pending, else HALT.
  - MEM is never interrupted by `run` falling.
- HALT:
  - `halted`=1.
  - Rising edge of `run` → EXEC.
  - Rising edge of `step` sets `step_pend` and goes to EXEC. Exactly one instruction issues, including its MEM cycles, then `step_pend` clears and the state returns to HALT.
  - `step` edges outside HALT are ignored.
  - Edge detection uses registered previous values.
- Simultaneous `run` and `step` rising edges in HALT: `run` wins, `step_pend` is not set.
- `rst` asserted mid-MEM: the store is aborted (no `memWrite` pulse) and the state machine goes to RST.

Decomposition:
- Package `dp_pkg`: opcode localparams, ALU function codes, state encoding.
- One natural sub-module, `dp_decode`: combinational opcode/func → control vector.
- `dp_sequencer` holds the FSM, counters, edge detectors, and output gating.

Test Plan:
- Reset hold: `rst` low 3 cycles then high, `run`=1, `RST_CYC`=2 → `rstPC`=1 for exactly 2 cycles after release, then state EXEC with `halted`=0.
- C-type ADD: `instOut`=1000, `funcOut`=0x04 → `regSel`=1, `selALU`=1, `regWrite`=1, `nop`=1, `funcCtrl`=000, `pcSel`=1, `ldPC`=1 in the same cycle.
- LOAD with `DM_WAIT`=2 → cycle 0 `memRead`=1 and `ldPC`=0; cycle 1 `memRead`=1; cycle 2 `memRead`=1, `selDm`=1, `regWrite`=1, `ldPC`=1. STORE with `DM_WAIT`=2 → `memWrite` high only in cycle 2.
- HLT then step: `instOut`=0111 → next cycle `halted`=1. One `step` pulse issues exactly one ADDI (`inSel`=1, `funcCtrl`=000), then `halted`=1 again. A `run` rising edge resumes free-run.
- Illegal: `instOut`=0101 → `nop`=0, `regWrite`=0, `pcSel`=1, `illegal`=1 and still 1 ten cycles later. C-type `funcOut`=0x0C also sets `illegal`.
- Reset mid-MEM: STORE with `DM_WAIT`=3, assert `rst`=0 in cycle 2 → `memWrite` never pulses, state RST with `rstPC`=1 immediately.
